// File: rtl/video_mono_converter.sv
`default_nettype none
// ============================================================================
//  Module      : video_mono_converter
//  Description : Three-stage colour / green / amber / B&W monitor emulation
//                with fixed-point luma, optional inversion and delay-matched syncs.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_mono_converter #(
   parameter int CW = 6,
   parameter int OW = 8,
   parameter int KR = 54,
   parameter int KG = 183,
   parameter int KB = 19
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce_pix,
   input  logic [1:0]    mode_i,
   input  logic          invert_i,
   input  logic [CW-1:0] r_i,
   input  logic [CW-1:0] g_i,
   input  logic [CW-1:0] b_i,
   input  logic          hs_i,
   input  logic          vs_i,
   input  logic          de_i,
   output logic [OW-1:0] r_o,
   output logic [OW-1:0] g_o,
   output logic [OW-1:0] b_o,
   output logic          hs_o,
   output logic          vs_o,
   output logic          de_o
);
   localparam int            PW            = CW + 8;
   localparam logic [1:0]    c_MODE_COLOUR = 2'd0;
   localparam logic [1:0]    c_MODE_GREEN  = 2'd1;
   localparam logic [1:0]    c_MODE_AMBER  = 2'd2;
   localparam logic [1:0]    c_MODE_BW     = 2'd3;
   localparam logic [CW-1:0] c_YMAX        = {CW{1'b1}};

   logic [1:0]    r_mode;
   logic          r_inv;
   logic          w_vs_rise;

   logic [CW-1:0] r_s1_r, r_s1_g, r_s1_b;
   logic [PW-1:0] r_s1_pr, r_s1_pg, r_s1_pb;
   logic [1:0]    r_s1_mode;
   logic          r_s1_inv;
   logic          r_s1_hs, r_s1_vs, r_s1_de;

   logic [PW-1:0] w_pr, w_pg, w_pb;
   logic [PW+1:0] w_sum;
   logic [CW+1:0] w_y_full;
   logic [CW-1:0] w_y_sat, w_y;

   logic [CW-1:0] r_s2_r, r_s2_g, r_s2_b, r_s2_y;
   logic [1:0]    r_s2_mode;
   logic          r_s2_hs, r_s2_vs, r_s2_de;

   logic [CW-1:0] w_map_r, w_map_g, w_map_b;
   logic [OW-1:0] w_exp_r, w_exp_g, w_exp_b;

   // r_s1_vs is the vs_i sampled on the previous ce edge
   assign w_vs_rise = vs_i & ~r_s1_vs;

   assign w_pr = PW'(KR) * PW'(r_i);
   assign w_pg = PW'(KG) * PW'(g_i);
   assign w_pb = PW'(KB) * PW'(b_i);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode <= c_MODE_COLOUR;
         r_inv  <= 1'b0;
      end else if (ce_pix && w_vs_rise) begin
         r_mode <= mode_i;
         r_inv  <= invert_i;
      end
   end

   // The mode travels with the pixel, so a pixel sampled on the latch edge still uses the old mode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_r    <= '0;
         r_s1_g    <= '0;
         r_s1_b    <= '0;
         r_s1_pr   <= '0;
         r_s1_pg   <= '0;
         r_s1_pb   <= '0;
         r_s1_mode <= c_MODE_COLOUR;
         r_s1_inv  <= 1'b0;
         r_s1_hs   <= 1'b0;
         r_s1_vs   <= 1'b0;
         r_s1_de   <= 1'b0;
      end else if (ce_pix) begin
         r_s1_r    <= r_i;
         r_s1_g    <= g_i;
         r_s1_b    <= b_i;
         r_s1_pr   <= w_pr;
         r_s1_pg   <= w_pg;
         r_s1_pb   <= w_pb;
         r_s1_mode <= r_mode;
         r_s1_inv  <= r_inv;
         r_s1_hs   <= hs_i;
         r_s1_vs   <= vs_i;
         r_s1_de   <= de_i;
      end
   end

   assign w_sum    = (PW+2)'(r_s1_pr) + (PW+2)'(r_s1_pg) + (PW+2)'(r_s1_pb) + (PW+2)'(128);
   assign w_y_full = w_sum[PW+1:8];
   assign w_y_sat  = (w_y_full > {2'b00, c_YMAX}) ? c_YMAX : w_y_full[CW-1:0];
   assign w_y      = r_s1_inv ? (c_YMAX - w_y_sat) : w_y_sat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s2_r    <= '0;
         r_s2_g    <= '0;
         r_s2_b    <= '0;
         r_s2_y    <= '0;
         r_s2_mode <= c_MODE_COLOUR;
         r_s2_hs   <= 1'b0;
         r_s2_vs   <= 1'b0;
         r_s2_de   <= 1'b0;
      end else if (ce_pix) begin
         r_s2_r    <= r_s1_r;
         r_s2_g    <= r_s1_g;
         r_s2_b    <= r_s1_b;
         r_s2_y    <= w_y;
         r_s2_mode <= r_s1_mode;
         r_s2_hs   <= r_s1_hs;
         r_s2_vs   <= r_s1_vs;
         r_s2_de   <= r_s1_de;
      end
   end

   always_comb begin
      w_map_r = r_s2_r;
      w_map_g = r_s2_g;
      w_map_b = r_s2_b;
      case (r_s2_mode)
         c_MODE_GREEN: begin
            w_map_r = '0;
            w_map_g = r_s2_y;
            w_map_b = '0;
         end
         c_MODE_AMBER: begin
            w_map_r = r_s2_y;
            w_map_g = {1'b0, r_s2_y[CW-1:1]};
            w_map_b = '0;
         end
         c_MODE_BW: begin
            w_map_r = r_s2_y;
            w_map_g = r_s2_y;
            w_map_b = r_s2_y;
         end
         default: ;
      endcase
   end

   // MSB replication fills the extra low bits so full scale maps to full scale
   generate
      if (OW > CW) begin : g_expand
         assign w_exp_r = {w_map_r, w_map_r[CW-1 -: OW-CW]};
         assign w_exp_g = {w_map_g, w_map_g[CW-1 -: OW-CW]};
         assign w_exp_b = {w_map_b, w_map_b[CW-1 -: OW-CW]};
      end else begin : g_passthru
         assign w_exp_r = w_map_r;
         assign w_exp_g = w_map_g;
         assign w_exp_b = w_map_b;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_o  <= '0;
         g_o  <= '0;
         b_o  <= '0;
         hs_o <= 1'b0;
         vs_o <= 1'b0;
         de_o <= 1'b0;
      end else if (ce_pix) begin
         r_o  <= r_s2_de ? w_exp_r : '0;
         g_o  <= r_s2_de ? w_exp_g : '0;
         b_o  <= r_s2_de ? w_exp_b : '0;
         hs_o <= r_s2_hs;
         vs_o <= r_s2_vs;
         de_o <= r_s2_de;
      end
   end

endmodule
`default_nettype wire
